// File: rtl/sdram_host_pkg.sv
// Shared types and FSM state encodings for sdram_host_port.
package sdram_host_pkg;

    typedef logic [23:0] ram_addr_t;
    typedef logic [15:0] ram_data_t;
    typedef logic [2:0]  state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_WAIT_RD = 3'd2;
    localparam state_t ST_GUARD   = 3'd3;
    localparam state_t ST_DRAIN   = 3'd4;

endpackage

// File: rtl/sdram_host_port.sv
// CPU-side initiator for the SDRAM FIFO interface: one request in flight, one read outstanding.
// Define SDRAM_HOST_TIMEOUT_EN to add the read timeout and stale-read draining.
module sdram_host_port
    import sdram_host_pkg::*;
#(
    parameter int ACK_GUARD      = 2
`ifdef SDRAM_HOST_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int STALE_W        = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [23:0] ram_addr,
    output logic [15:0] ram_wr_data,
    output logic        ram_wr_en,
    output logic        ram_rd_en,
    input  logic        ram_busy,
    input  logic        ram_rd_ready,
    input  logic [15:0] ram_rd_data,
    output logic        ram_rd_ack
);

    localparam int GUARD_W = $clog2(ACK_GUARD + 1);

    state_t             state;
    logic [GUARD_W-1:0] guard_cnt;
    logic               idle_open;

`ifdef SDRAM_HOST_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0]  wait_cnt;
    logic [STALE_W-1:0] stale_cnt;

    // New requests stay blocked until every abandoned read has been drained.
    assign idle_open = !ram_busy && (stale_cnt == '0);
`else
    assign idle_open = !ram_busy;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            guard_cnt   <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_rd_ack  <= 1'b0;
`ifdef SDRAM_HOST_TIMEOUT_EN
            rsp_err     <= 1'b0;
            wait_cnt    <= '0;
            stale_cnt   <= '0;
`endif
        end else begin
            rsp_valid  <= 1'b0;
            ram_rd_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        ram_addr    <= req_addr;
                        ram_wr_data <= req_wdata;
                        ram_wr_en   <= req_we;
                        ram_rd_en   <= !req_we;
                        req_ready   <= 1'b0;
                        state       <= ST_ISSUE;
                    end
`ifdef SDRAM_HOST_TIMEOUT_EN
                    else if (stale_cnt != '0 && ram_rd_ready) begin
                        ram_rd_ack <= 1'b1;
                        req_ready  <= 1'b0;
                        state      <= ST_DRAIN;
                    end
`endif
                    else begin
                        req_ready <= idle_open;
                    end
                end
                // The enable is held through busy cycles; the FIFO takes it on the first non-busy edge.
                ST_ISSUE: begin
                    if (!ram_busy) begin
                        ram_wr_en <= 1'b0;
                        ram_rd_en <= 1'b0;
                        state     <= ram_rd_en ? ST_WAIT_RD : ST_IDLE;
`ifdef SDRAM_HOST_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT_RD: begin
                    if (ram_rd_ready) begin
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= ram_rd_data;
                        ram_rd_ack <= 1'b1;
                        guard_cnt  <= '0;
                        state      <= ST_GUARD;
`ifdef SDRAM_HOST_TIMEOUT_EN
                        rsp_err    <= 1'b0;
`endif
                    end
`ifdef SDRAM_HOST_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        if (stale_cnt != '1) begin
                            stale_cnt <= stale_cnt + 1'b1;
                        end
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                // Covers the lag before the read-data FIFO's not-empty flag reflects the pop.
                ST_GUARD: begin
                    if (guard_cnt == GUARD_W'(ACK_GUARD - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
`ifdef SDRAM_HOST_TIMEOUT_EN
                    stale_cnt <= stale_cnt - 1'b1;
                    guard_cnt <= '0;
                    state     <= ST_GUARD;
`else
                    state     <= ST_IDLE;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
